wb_stage_regfile: RTL
=====================

Name: wb_stage_regfile

Overview:
- Writeback-side consumer of the MEM/WB pipeline register bundle (pc, inst, aluout, WB_signal, readdata, rd).
- Selects the writeback value and performs load byte/halfword extraction and sign/zero extension.
- Writes the result into the 32x32 integer register file and serves the two ID-stage read ports with same-cycle write-through bypass.
- Keeps the cycle and retired-instruction counters (mcycle/minstret source).

Parameters:
- XLEN, 32, datapath width
- NREG, 32, number of architectural registers; x0 is hardwired to zero

Ports:
- clk  input  1  clock
- rst  input  1  reset
- wb_pc  input  32  PC of the instruction in WB
- wb_inst  input  32  instruction word in WB; funct3 = inst[14:12]
- wb_aluout  input  32  ALU result / effective address
- wb_signal  input  5  [0] reg_we, [2:1] wb_sel, [3] valid (not a bubble), [4] reserved (ignored)
- wb_readdata  input  32  raw 32-bit word returned by data memory for the load address
- wb_rd  input  5  destination register index
- rs1_addr  input  5  ID read port 1 index
- rs2_addr  input  5  ID read port 2 index
- rs1_data  output  32  read port 1 data (combinational)
- rs2_data  output  32  read port 2 data (combinational)
- wb_wdata  output  32  final writeback value (combinational; to the forwarding unit)
- wb_we  output  1  effective write enable = reg_we & valid & (rd != 0)
- cycle_cnt  output  64  clock cycles since reset
- instret_cnt  output  64  retired instructions since reset

Behaviour:
- Reset: rst is asynchronous and active-high; the clock is clk.
  - Asserting rst clears all NREG registers, cycle_cnt and instret_cnt to 0 immediately.
  - While rst is high, rs1_data and rs2_data therefore read 0.
  - Reset mid-operation discards any write pending in that cycle.
- wb_sel decode:
  - 00: aluout.
  - 01: extended load data.
  - 10: pc+4 (wrapping, modulo 2^32).
  - 11: aluout (lui/auipc path).
- Load extraction (wb_sel=01). off = aluout[1:0]; the byte lane is readdata[8*off+7 : 8*off]; the halfword lane is readdata[31:16] if aluout[1], else [15:0]; aluout[0] is ignored for halfwords.
  - funct3 000 lb: sign-extended byte.
  - funct3 001 lh: sign-extended halfword.
  - funct3 010 lw: full word.
  - funct3 100 lbu: zero-extended byte.
  - funct3 101 lhu: zero-extended halfword.
  - Any other funct3: full word, no extension.
- Register write:
  - Occurs on posedge clk when wb_we=1: reg[wb_rd] <= wb_wdata.
  - Writes to x0 are dropped; reg[0] always reads 0.
  - A bubble (valid=0) never writes, regardless of reg_we.
- Read ports:
  - Each port returns 0 if its address is 0.
  - Otherwise, if wb_we=1 and the address equals wb_rd, it returns wb_wdata (write-through bypass, so WB→ID needs no stall).
  - Otherwise it returns the stored reg[addr].
  - Both ports may bypass simultaneously.
- Counters:
  - cycle_cnt increments by 1 every posedge clk while rst=0.
  - instret_cnt increments by 1 on each posedge where valid=1, independent of reg_we, so stores and branches count.
  - Both counters wrap from 2^64-1 to 0.
- Latency: the written value is visible through the array one cycle after the write edge, and through the bypass in the same cycle.

Test Plan:
- Assert rst mid-run after writing x5=0x12345678 → rs1_addr=5 reads 0 immediately; cycle_cnt=0 and instret_cnt=0; after deassert, cycle_cnt counts 1,2,3 on successive edges.
- reg_we=1, valid=1, rd=0, aluout=0xDEADBEEF → wb_we=0; rs1_addr=0 reads 0 before and after the edge; instret_cnt increments by 1.
- Loads with readdata=0x80FF7F01 and funct3 lb: aluout=…3 → wb_wdata=0xFFFFFF80; lbu aluout=…2 → 0x000000FF; lh aluout=…2 → 0xFFFF80FF; lhu aluout=…0 → 0x00007F01; lw → 0x80FF7F01.
- Bypass: wb_we=1, rd=7, wb_wdata=0xA5A5A5A5, rs1_addr=7, rs2_addr=7 in the same cycle → both ports read 0xA5A5A5A5 before the edge; after the edge, with WB idle, both still read 0xA5A5A5A5 from the array.
- wb_sel=10, wb_pc=0xFFFFFFFC, rd=1 → x1=0x00000000 (wrap); wb_sel=10, wb_pc=0x00000100 → x1=0x00000104.
- Bubble: valid=0, reg_we=1, rd=3 → x3 is unchanged and instret_cnt is unchanged; cycle_cnt still increments.

Source files
------------

// File: rtl/wb_stage_regfile.sv
// wb_stage_regfile: writeback mux, load extension, 32x32 register file with write-through bypass, cycle/instret counters
module wb_stage_regfile #(
  parameter int XLEN = 32,
  parameter int NREG = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [XLEN-1:0] wb_pc,
  input  logic [31:0]     wb_inst,
  input  logic [XLEN-1:0] wb_aluout,
  input  logic [4:0]      wb_signal,
  input  logic [31:0]     wb_readdata,
  input  logic [4:0]      wb_rd,
  input  logic [4:0]      rs1_addr,
  input  logic [4:0]      rs2_addr,
  output logic [XLEN-1:0] rs1_data,
  output logic [XLEN-1:0] rs2_data,
  output logic [XLEN-1:0] wb_wdata,
  output logic            wb_we,
  output logic [63:0]     cycle_cnt,
  output logic [63:0]     instret_cnt
);
  logic [XLEN-1:0] regs [NREG];
  logic [2:0]      f3;
  logic [1:0]      sel;
  logic            valid;
  logic [7:0]      lb;
  logic [15:0]     lh;
  logic [XLEN-1:0] ld;
  logic            unused;
  assign unused = ^{wb_signal[4], wb_inst[31:15], wb_inst[11:0]};
  assign f3    = wb_inst[14:12];
  assign sel   = wb_signal[2:1];
  assign valid = wb_signal[3];
  assign lb    = wb_readdata[8*wb_aluout[1:0] +: 8];
  assign lh    = wb_aluout[1] ? wb_readdata[31:16] : wb_readdata[15:0];
  always_comb begin
    ld = f3 == 3'b000 ? {{(XLEN-8){lb[7]}}, lb} :
         f3 == 3'b001 ? {{(XLEN-16){lh[15]}}, lh} :
         f3 == 3'b100 ? {{(XLEN-8){1'b0}}, lb} :
         f3 == 3'b101 ? {{(XLEN-16){1'b0}}, lh} : wb_readdata;
    wb_wdata = sel == 2'b01 ? ld : sel == 2'b10 ? wb_pc + XLEN'(4) : wb_aluout;
    wb_we    = wb_signal[0] & valid & (wb_rd != 5'd0);
    rs1_data = rs1_addr == 5'd0 ? '0 : (wb_we && rs1_addr == wb_rd) ? wb_wdata : regs[rs1_addr];
    rs2_data = rs2_addr == 5'd0 ? '0 : (wb_we && rs2_addr == wb_rd) ? wb_wdata : regs[rs2_addr];
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NREG; i++) regs[i] <= '0;
      cycle_cnt   <= '0;
      instret_cnt <= '0;
    end else begin
      if (wb_we) regs[wb_rd] <= wb_wdata;
      cycle_cnt   <= cycle_cnt + 64'd1;
      instret_cnt <= instret_cnt + 64'(valid);
    end
  end
endmodule
